// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side controller for an asynchronous FIFO.
// Pulls words out of the FIFO (1-cycle read latency) into a 2-entry
// in-order skid buffer and presents them on a valid/ready stream.
// It counts accepted words in a saturating counter.
// Optional feature: define FIFO_RD_CTRL_LAST_EN to add the burst counter
// that drives m_last. Without it, m_last is tied low.
module fifo_rd_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_ren,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  // Legal burst lengths are 2..256. An out-of-range value elaborates this
  // (empty) block; it is a marker only and adds no logic.
  if ((BURST_LEN < 2) || (BURST_LEN > 256)) begin : g_burst_len_out_of_range
  end

  // Buffer state: entry 0 is always the head of the stream.
  logic                  run_q,      run_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            occ_q,      occ_d;
  logic                  valid_q,    valid_d;
  logic [DATA_WIDTH-1:0] buf0_q,     buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q,     buf1_d;
  logic [CNT_WIDTH-1:0]  cnt_q,      cnt_d;

  logic                  pop_s;
  logic                  push_s;
  logic [2:0]            level_s;

  // Handshake and read-enable decision: a read is issued only when the
  // words already held or on their way, minus the one leaving now, leave room.
  // run_q keeps reads off until the first clock edge out of reset.
  always_comb begin
    pop_s    = (occ_q != 2'd0) & m_ready;
    push_s   = inflight_q;
    level_s  = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_s};
    if (run_q && !fifo_empty && (level_s < 3'd2)) begin
      fifo_ren = 1'b1;
    end else begin
      fifo_ren = 1'b0;
    end
  end

  // Buffer next state: the in-flight word lands behind whatever is still
  // held after this cycle's pop, so order is preserved on simultaneous push/pop.
  always_comb begin
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    occ_d      = occ_q;
    run_d      = 1'b1;
    inflight_d = fifo_ren;
    case ({push_s, pop_s})
      2'b00: begin
        occ_d = occ_q;
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b10: begin
        if (occ_q == 2'd0) begin
          buf0_d = fifo_dout;
        end else begin
          buf1_d = fifo_dout;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = fifo_dout;
        end else begin
          buf0_d = buf1_q;
          buf1_d = fifo_dout;
        end
        occ_d = occ_q;
      end
      default: begin
        occ_d = occ_q;
      end
    endcase
    valid_d = (occ_d != 2'd0);
  end

  // Accepted-word counter: counts transfers and sticks at all-ones.
  always_comb begin
    if (pop_s && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers; reset discards buffered and in-flight words.
  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) begin
      run_q      <= 1'b0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      valid_q    <= 1'b0;
      buf0_q     <= {DATA_WIDTH{1'b0}};
      buf1_q     <= {DATA_WIDTH{1'b0}};
      cnt_q      <= {CNT_WIDTH{1'b0}};
    end else begin
      run_q      <= run_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      valid_q    <= valid_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      cnt_q      <= cnt_d;
    end
  end

  assign m_data   = buf0_q;
  assign m_valid  = valid_q;
  assign word_cnt = cnt_q;

`ifdef FIFO_RD_CTRL_LAST_EN
  localparam int unsigned BW = $clog2(BURST_LEN);
  localparam logic [BW-1:0] LAST_IDX = BW'(BURST_LEN - 1);

  logic [BW-1:0] burst_q, burst_d;
  logic          last_q,  last_d;

  // Burst position: advances on each transfer, wraps after the final word.
  always_comb begin
    if (pop_s) begin
      if (burst_q == LAST_IDX) begin
        burst_d = {BW{1'b0}};
      end else begin
        burst_d = burst_q + BW'(1);
      end
    end else begin
      burst_d = burst_q;
    end
    last_d = (burst_d == LAST_IDX);
  end

  // Burst position and registered last flag.
  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) begin
      burst_q <= {BW{1'b0}};
      last_q  <= 1'b0;
    end else begin
      burst_q <= burst_d;
      last_q  <= last_d;
    end
  end

  assign m_last = last_q;
`else
  assign m_last = 1'b0;
`endif

endmodule
